mem_wb_skid_reg: RTL and testbench

Parametrised, flow-controlled MEM→WB pipeline stage register for the pipelined CPU. It replaces the fixed-width, always-advancing boundary register with a valid/ready stage. An optional two-entry skid buffer lets the stage absorb a one-cycle writeback stall without a combinational ready path. It also supports a flush that squashes in-flight writes, and keeps a saturating stall counter for debug. It sits between the memory stage and the register-file write port and is clocked on ram_clk.

---
 rtl/mem_wb_skid_reg.sv | 164 ++++++++++++++++
 tb/tb_mem_wb_skid_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg
//   Flow-controlled MEM->WB pipeline stage register. Holds write-back
//   entries between the memory stage and the register-file write port.
//   With EN_SKID=1 a second (skid) entry absorbs a one-cycle writeback stall.
//   In that mode in_ready is a registered flag. With EN_SKID=0 there is a
//   single entry and in_ready is combinational.
//
// Ports
//   ram_clk    stage clock, rising edge
//   rst_n      synchronous active-low reset
//   flush      squash all held entries; discards any input this cycle
//   in_valid / in_ready                        MEM-side handshake
//   in_rf_we, in_wR, in_wD, in_pc              incoming entry
//   out_valid / out_ready                      WB-side handshake
//   out_rf_we, out_wR, out_wD, out_pc          held entry (rf_we gated by valid)
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
module mem_wb_skid_reg #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned PCW     = 32,
  parameter int unsigned EN_SKID = 1,
  parameter int unsigned CNTW    = 16
) (
  input  logic            ram_clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_rf_we,
  input  logic [AW-1:0]   in_wR,
  input  logic [DW-1:0]   in_wD,
  input  logic [PCW-1:0]  in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_rf_we,
  output logic [AW-1:0]   out_wR,
  output logic [DW-1:0]   out_wD,
  output logic [PCW-1:0]  out_pc,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic           rdy_q;
  logic           in_xfer, out_xfer;
  logic           ld_main_in, ld_main_skid, ld_skid;

  logic           m_we, s_we;
  logic [AW-1:0]  m_wr, s_wr;
  logic [DW-1:0]  m_wd, s_wd;
  logic [PCW-1:0] m_pc, s_pc;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register; rdy_q tracks "next state is not FULL" so in_ready
  // never depends on out_ready in skid mode.
  always_ff @(posedge ram_clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != S_FULL);
    end
  end

  // Next-state and load-select logic. Flush overrides every transfer.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d    = S_ONE;
          ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (out_xfer && in_xfer) begin
          ld_main_in = 1'b1;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end else if (in_xfer && (EN_SKID != 0)) begin
          state_d = S_FULL;
          ld_skid = 1'b1;
        end
      end
      S_FULL: begin
        if (out_xfer) begin
          state_d      = S_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d      = S_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // Output logic.
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    in_ready  = (EN_SKID != 0) ? rdy_q : (!out_valid || out_ready);
    out_rf_we = out_valid & m_we;
    out_wR    = m_wr;
    out_wD    = m_wd;
    out_pc    = m_pc;
  end

  // Entry storage.
  always_ff @(posedge ram_clk) begin
    if (!rst_n) begin
      m_we <= 1'b0;
      m_wr <= '0;
      m_wd <= '0;
      m_pc <= '0;
      s_we <= 1'b0;
      s_wr <= '0;
      s_wd <= '0;
      s_pc <= '0;
    end else begin
      if (ld_main_in) begin
        m_we <= in_rf_we;
        m_wr <= in_wR;
        m_wd <= in_wD;
        m_pc <= in_pc;
      end else if (ld_main_skid) begin
        m_we <= s_we;
        m_wr <= s_wr;
        m_wd <= s_wd;
        m_pc <= s_pc;
      end
      if (ld_skid) begin
        s_we <= in_rf_we;
        s_wr <= in_wR;
        s_wd <= in_wD;
        s_pc <= in_pc;
      end
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge ram_clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: skid-mode instance with a scoreboard
// queue, a combinational-mode instance and a 3-bit-counter instance, all
// sharing the same input stimulus.
module tb_mem_wb_skid_reg;

  logic        ram_clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_rf_we;
  logic [4:0]  in_wR;
  logic [31:0] in_wD;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_rf_we;
  logic [4:0]  a_out_wR;
  logic [31:0] a_out_wD, a_out_pc;
  logic [15:0] a_stall_cnt;

  logic        z_in_ready, z_out_valid, z_out_rf_we;
  logic [4:0]  z_out_wR;
  logic [31:0] z_out_wD, z_out_pc;
  logic [15:0] z_stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_rf_we;
  logic [4:0]  s_out_wR;
  logic [31:0] s_out_wD, s_out_pc;
  logic [2:0]  s_stall_cnt;

  mem_wb_skid_reg #(.DW(32), .AW(5), .PCW(32), .EN_SKID(1), .CNTW(16)) dut (
    .ram_clk(ram_clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_rf_we(in_rf_we),
    .in_wR(in_wR), .in_wD(in_wD), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_rf_we(a_out_rf_we),
    .out_wR(a_out_wR), .out_wD(a_out_wD), .out_pc(a_out_pc),
    .stall_cnt(a_stall_cnt)
  );

  mem_wb_skid_reg #(.DW(32), .AW(5), .PCW(32), .EN_SKID(0), .CNTW(16)) dut_comb (
    .ram_clk(ram_clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_rf_we(in_rf_we),
    .in_wR(in_wR), .in_wD(in_wD), .in_pc(in_pc),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_rf_we(z_out_rf_we),
    .out_wR(z_out_wR), .out_wD(z_out_wD), .out_pc(z_out_pc),
    .stall_cnt(z_stall_cnt)
  );

  mem_wb_skid_reg #(.DW(32), .AW(5), .PCW(32), .EN_SKID(1), .CNTW(3)) dut_sat (
    .ram_clk(ram_clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_rf_we(in_rf_we),
    .in_wR(in_wR), .in_wD(in_wD), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_rf_we(s_out_rf_we),
    .out_wR(s_out_wR), .out_wD(s_out_wD), .out_pc(s_out_pc),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic we);
    ent_t e;
    logic [31:0] p;
    p    = pc;
    e.we = we;
    e.wr = p[6:2] + 5'd1;
    e.wd = {p[15:0], ~p[15:0]};
    e.pc = p;
    return e;
  endfunction

  // One clock of the skid-mode scoreboard: drive, check before the edge,
  // update the queue, then advance past the edge.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic we,
                     input logic ordy, input logic exp_acc,
                     input logic exp_ov, input logic exp_ir);
    ent_t e;
    e         = mk(pc, we);
    in_valid  = iv;
    in_rf_we  = e.we;
    in_wR     = e.wr;
    in_wD     = e.wd;
    in_pc     = e.pc;
    out_ready = ordy;
    @(negedge ram_clk);
    chk("out_valid", {63'd0, a_out_valid}, {63'd0, exp_ov});
    chk("in_ready", {63'd0, a_in_ready}, {63'd0, exp_ir});
    if (exp_ov) begin
      chk("sb_nonempty", {63'd0, q.size() > 0}, 64'd1);
      if (q.size() > 0) begin
        chk("out_pc", {32'd0, a_out_pc}, {32'd0, q[0].pc});
        chk("out_wR", {59'd0, a_out_wR}, {59'd0, q[0].wr});
        chk("out_wD", {32'd0, a_out_wD}, {32'd0, q[0].wd});
        chk("out_rf_we", {63'd0, a_out_rf_we}, {63'd0, q[0].we});
        if (ordy) void'(q.pop_front());
      end
    end else begin
      chk("rf_we_idle", {63'd0, a_out_rf_we}, 64'd0);
    end
    if (flush || !rst_n) q.delete();
    else if (iv && exp_acc) q.push_back(e);
    @(posedge ram_clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_rf_we", {63'd0, a_out_rf_we}, 64'd0);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("rst_wR", {59'd0, a_out_wR}, 64'd0);
    chk("rst_wD", {32'd0, a_out_wD}, 64'd0);
    chk("rst_pc", {32'd0, a_out_pc}, 64'd0);
    chk("rst_stall", {48'd0, a_stall_cnt}, 64'd0);
    chk("rst_stall_sat", {61'd0, s_stall_cnt}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rf_we = 1'b0;
    in_wR = '0; in_wD = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge ram_clk);
    #1;
    chk_reset();
    rst_n = 1'b1;

    // Streaming, out_ready held high
    for (int unsigned i = 0; i < 8; i++)
      cyc(1'b1, 32'(i * 4), 1'b1, 1'b1, 1'b1, (i > 0), 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("stream_stall", {48'd0, a_stall_cnt}, 64'd0);

    // Skid fill: A accepted, B to skid, C refused while FULL
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("skid_stall", {48'd0, a_stall_cnt}, 64'd3);
    cyc(1'b1, 32'h48, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h48, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("skid_stall_hold", {48'd0, a_stall_cnt}, 64'd3);

    // Flush in FULL with an input offered
    cyc(1'b1, 32'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h54, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    cyc(1'b1, 32'h58, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    flush = 1'b0;
    chk("flush_stall_kept", {48'd0, a_stall_cnt}, 64'd5);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-stream in FULL, then D with one-cycle latency
    cyc(1'b1, 32'h60, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h64, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    cyc(1'b1, 32'h68, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk_reset();
    cyc(1'b1, 32'h70, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Saturation of the 3-bit counter over 10 stall cycles
    cyc(1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int unsigned k = 1; k <= 10; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("sat_cnt", {61'd0, s_stall_cnt}, (k < 7) ? 64'(k) : 64'd7);
    end
    chk("wide_cnt", {48'd0, a_stall_cnt}, 64'd10);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Combinational-ready instance
    rst_n = 1'b0;
    @(posedge ram_clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    in_valid = 1'b1; in_pc = 32'h90; in_wR = 5'd3; in_wD = 32'h1234; in_rf_we = 1'b1;
    out_ready = 1'b0;
    #2 chk("comb_ir_empty", {63'd0, z_in_ready}, 64'd1);
    @(posedge ram_clk);
    #1;
    in_valid = 1'b0;
    #2;
    chk("comb_ir_low", {63'd0, z_in_ready}, 64'd0);
    chk("comb_ov", {63'd0, z_out_valid}, 64'd1);
    chk("comb_pc", {32'd0, z_out_pc}, 64'h90);
    out_ready = 1'b1;
    #2 chk("comb_ir_follow", {63'd0, z_in_ready}, 64'd1);
    out_ready = 1'b0;
    #2 chk("comb_ir_drop", {63'd0, z_in_ready}, 64'd0);
    @(posedge ram_clk);
    #1;
    chk("comb_hold_pc", {32'd0, z_out_pc}, 64'h90);
    chk("comb_hold_ov", {63'd0, z_out_valid}, 64'd1);
    in_valid = 1'b1; in_pc = 32'h94; in_wR = 5'd4; out_ready = 1'b1;
    #2 chk("comb_ir_xfer", {63'd0, z_in_ready}, 64'd1);
    @(posedge ram_clk);
    #1;
    chk("comb_repl_pc", {32'd0, z_out_pc}, 64'h94);
    chk("comb_repl_wR", {59'd0, z_out_wR}, 64'd4);
    chk("comb_repl_we", {63'd0, z_out_rf_we}, 64'd1);
    in_valid = 1'b0;
    @(posedge ram_clk);
    #1;
    chk("comb_drain_ov", {63'd0, z_out_valid}, 64'd0);
    chk("comb_drain_we", {63'd0, z_out_rf_we}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
